pdm_mic_emulator: RTL and testbench

Synthesizable PDM microphone emulator: the transmitting end of the microphone link that the CIC decimator receives. It accepts signed PCM samples over a valid/ready handshake and converts them with a first-order sigma-delta modulator into a 1-bit PDM stream. The stream is clocked by the externally supplied microphone clock, which is normally the CIC's 1 MHz `clk_out`, and is driven on the half-period selected by `channel`. It sits in the test/loopback path so the microphone pre-processing chain can be exercised without a physical microphone.

---
 rtl/pdm_mic_emulator.sv | 120 ++++++++++++
 tb/tb_pdm_mic_emulator.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_emulator.sv
// PDM microphone emulator: PCM samples in over valid/ready, first-order sigma-delta
// bitstream out, launched on the mic_clk half-period chosen by channel.
module pdm_mic_emulator #(
  parameter int PCM_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [PCM_WIDTH-1:0] pcm_in,
  input  logic                        pcm_valid,
  output logic                        pcm_ready,
  input  logic [7:0]                  dec_num,
  input  logic                        mic_clk,
  input  logic                        channel,
  output logic                        data_out,
  output logic                        data_oe,
  output logic                        underrun
);

  localparam int W = PCM_WIDTH;

  logic         sync0_q, sync0_d, sync1_q, sync1_d, hist_q, hist_d;
  logic [1:0]   count_q, count_d;
  logic [W-1:0] fifo_q [2];
  logic [W-1:0] fifo_d [2];
  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] acc_q, acc_d;
  logic [7:0]   bit_cntr_q, bit_cntr_d;
  logic         data_out_q, data_out_d;
  logic         data_oe_q, data_oe_d;
  logic         underrun_q, underrun_d;

  logic         rise, fall, active, due, push, pop;
  logic [1:0]   level_after_pop;
  logic [W-1:0] sample, offset;
  logic [W:0]   sum;

  assign pcm_ready = (count_q != 2'd2) && !rst;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign underrun  = underrun_q;

  always_comb begin
    // NOTE: every _d gets its default first so no path through this block infers a latch.
    sync0_d    = mic_clk;
    sync1_d    = sync0_q;
    hist_d     = sync1_q;
    count_d    = count_q;
    fifo_d     = fifo_q;
    cur_d      = cur_q;
    acc_d      = acc_q;
    bit_cntr_d = bit_cntr_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;

    rise   = sync1_q & ~hist_q;
    fall   = ~sync1_q & hist_q;
    active = channel ? rise : fall;
    due    = active && (bit_cntr_q == 8'd0);
    pop    = due && (count_q != 2'd0);
    push   = pcm_valid && pcm_ready;

    underrun_d = due && (count_q == 2'd0);

    if (rise)      data_oe_d = channel;
    else if (fall) data_oe_d = ~channel;

    // The bit emitted on a pop edge already uses the freshly popped sample.
    sample = pop ? fifo_q[0] : cur_q;
    offset = sample ^ {1'b1, {(W-1){1'b0}}};
    sum    = {1'b0, acc_q} + {1'b0, offset};

    if (active) begin
      data_out_d = sum[W];
      acc_d      = sum[W-1:0];
      bit_cntr_d = (bit_cntr_q >= dec_num) ? 8'd0 : bit_cntr_q + 8'd1;
    end

    if (pop) begin
      cur_d     = fifo_q[0];
      fifo_d[0] = fifo_q[1];
    end

    // A push lands behind whatever survives this cycle's pop.
    level_after_pop = count_q - {1'b0, pop};
    if (push) fifo_d[level_after_pop[0]] = pcm_in;
    count_d = level_after_pop + {1'b0, push};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q    <= 1'b0;
      sync1_q    <= 1'b0;
      hist_q     <= 1'b0;
      count_q    <= 2'd0;
      cur_q      <= '0;
      acc_q      <= '0;
      bit_cntr_q <= 8'd0;
      data_out_q <= 1'b0;
      data_oe_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sync0_q    <= sync0_d;
      sync1_q    <= sync1_d;
      hist_q     <= hist_d;
      count_q    <= count_d;
      cur_q      <= cur_d;
      acc_q      <= acc_d;
      bit_cntr_q <= bit_cntr_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// Self-checking bench for pdm_mic_emulator: a queue/integer model of the FIFO,
// scheduler and modulator is compared with the DUT on every clk cycle.
module tb_pdm_mic_emulator;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] pcm_in;
  logic               pcm_valid;
  logic               pcm_ready;
  logic [7:0]         dec_num;
  logic               mic_clk;
  logic               channel;
  logic               data_out;
  logic               data_oe;
  logic               underrun;

  always #10 clk = ~clk;

  pdm_mic_emulator #(.PCM_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .pcm_in    (pcm_in),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .dec_num   (dec_num),
    .mic_clk   (mic_clk),
    .channel   (channel),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .underrun  (underrun)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int     q[$];
  int     m_acc, m_cur, m_cnt;
  bit     m_out, m_oe, m_urun;
  int     pend;
  bit     pend_rise;
  longint cyc = 0;
  longint first_pop_cyc;

  // Stimulus state
  int     src[$];
  bit     stream_en = 0;
  bit     stream_rand = 0;
  int     stream_val = 0;
  int     valid_pct = 100;

  // Observations
  bit     obs_bits[$];
  int     urun_cnt;
  bit     rec_accept = 0;
  longint accept_cyc;

  function automatic bit model_edge(bit is_rise);
    bit act;
    int tot;
    act  = is_rise ? (channel == 1'b1) : (channel == 1'b0);
    m_oe = is_rise ? channel : !channel;
    if (act) begin
      if (m_cnt == 0) begin
        if (q.size() > 0) begin
          m_cur = q.pop_front();
          if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end else begin
          m_urun = 1'b1;
        end
      end
      tot   = m_acc + m_cur + 32768;
      m_out = (tot >= 65536);
      m_acc = tot % 65536;
      m_cnt = (m_cnt >= int'(dec_num)) ? 0 : m_cnt + 1;
    end
    return act;
  endfunction

  function automatic int ones(int lo, int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(obs_bits[i]);
    return n;
  endfunction

  task automatic tick();
    bit exp_ready, push, act;
    act = 1'b0;
    if (stream_en && src.size() == 0)
      src.push_back(stream_rand ? int'($urandom_range(65535)) - 32768 : stream_val);
    pcm_valid = (src.size() > 0) && ($urandom_range(99) < valid_pct);
    pcm_in    = (src.size() > 0) ? 16'(src[0]) : 16'sd0;
    #1;
    exp_ready = !rst && (q.size() < 2);
    checks++;
    if (pcm_ready !== exp_ready)
      $display("FAIL pcm_ready @cyc %0d: got %b expected %b", cyc, pcm_ready, exp_ready);
    if (pcm_ready !== exp_ready) errors++;
    push = pcm_valid && exp_ready;
    if (rec_accept && pcm_valid && pcm_ready === 1'b1) begin
      accept_cyc = cyc + 1;
      rec_accept = 1'b0;
    end
    @(posedge clk);
    cyc++;
    m_urun = 1'b0;
    if (rst) begin
      q.delete();
      m_acc = 0; m_cur = 0; m_cnt = 0;
      m_out = 1'b0; m_oe = 1'b0; pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) act = model_edge(pend_rise);
      end
      if (push) q.push_back(src.pop_front());
    end
    @(negedge clk);
    checks++;
    if (data_out !== m_out) begin
      errors++;
      $display("FAIL data_out @cyc %0d: got %b expected %b", cyc, data_out, m_out);
    end
    checks++;
    if (data_oe !== m_oe) begin
      errors++;
      $display("FAIL data_oe @cyc %0d: got %b expected %b", cyc, data_oe, m_oe);
    end
    checks++;
    if (underrun !== m_urun) begin
      errors++;
      $display("FAIL underrun @cyc %0d: got %b expected %b", cyc, underrun, m_urun);
    end
    if (act) obs_bits.push_back(data_out === 1'b1);
    if (underrun === 1'b1) urun_cnt++;
  endtask

  // One mic_clk half-period; the edge reaches the outputs on the 3rd clk edge.
  task automatic half(int n_ticks);
    mic_clk   = ~mic_clk;
    pend      = 3;
    pend_rise = mic_clk;
    repeat (n_ticks) tick();
  endtask

  task automatic clear_obs();
    obs_bits.delete();
    urun_cnt = 0;
  endtask

  task automatic do_reset();
    stream_en   = 1'b0;
    stream_rand = 1'b0;
    valid_pct   = 100;
    src.delete();
    if (mic_clk) half(4);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    first_pop_cyc = -1;
    clear_obs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (data_out !== 1'b0 || data_oe !== 1'b0 || underrun !== 1'b0 || pcm_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%b oe=%b urun=%b ready=%b expected all 0",
               data_out, data_oe, underrun, pcm_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (pcm_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", pcm_ready);
    end
    tick();
    first_pop_cyc = -1;
    clear_obs();
  endtask

  task automatic test_silence();
    do_reset();
    channel = 1'b1; dec_num = 8'd3;
    stream_val = 0; stream_en = 1'b1;
    repeat (32) half(5);
    checks++;
    if (urun_cnt != 0) begin
      errors++;
      $display("FAIL silence_underrun: got %0d pulses expected 0", urun_cnt);
    end
    checks++;
    if (obs_bits.size() != 16) begin
      errors++;
      $display("FAIL silence_bitcount: got %0d expected 16", obs_bits.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs_bits[i] != bit'(i % 2)) begin
          errors++;
          $display("FAIL silence_bit%0d: got %0d expected %0d", i, obs_bits[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_full_scale();
    do_reset();
    stream_val = -32768; stream_en = 1'b1;
    repeat (40) half(4);
    checks++;
    if (obs_bits.size() != 20 || ones(0, 19) != 0) begin
      errors++;
      $display("FAIL full_neg: got %0d bits with ones present, expected 20 zero bits",
               obs_bits.size());
    end
    do_reset();
    stream_val = 32767; stream_en = 1'b1;
    repeat (40) half(4);
    checks++;
    if (obs_bits.size() != 20 || obs_bits[0] != 1'b0 || ones(0, 19) != 19) begin
      errors++;
      $display("FAIL full_pos: got %0d bits, first=%0d expected 20 bits, first 0 then 19 ones",
               obs_bits.size(), (obs_bits.size() > 0) ? int'(obs_bits[0]) : -1);
    end
  endtask

  task automatic test_density();
    do_reset();
    dec_num = 8'd15;
    stream_val = 16384; stream_en = 1'b1;
    repeat (256) half(4);
    checks++;
    if (obs_bits.size() != 128) begin
      errors++;
      $display("FAIL density_bitcount: got %0d expected 128", obs_bits.size());
    end else begin
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (ones(w * 64, w * 64 + 63) != 48) begin
          errors++;
          $display("FAIL density_window%0d: got %0d ones expected 48", w, ones(w * 64, w * 64 + 63));
        end
      end
    end
  endtask

  task automatic test_handshake();
    do_reset();
    channel = 1'b1; dec_num = 8'd3;
    src.push_back(-32768);
    src.push_back(32767);
    src.push_back(0);
    repeat (6) tick();
    #1;
    checks++;
    if (pcm_ready !== 1'b0 || pcm_valid !== 1'b1 || pcm_in !== 16'sd0) begin
      errors++;
      $display("FAIL handshake_stall: got ready=%b valid=%b data=%0d expected ready 0 with C held",
               pcm_ready, pcm_valid, pcm_in);
    end
    rec_accept = 1'b1;
    accept_cyc = -1;
    repeat (20) half(5);
    checks++;
    if (obs_bits.size() < 8 || ones(0, 4) != 0 || ones(5, 7) != 3) begin
      errors++;
      $display("FAIL handshake_order: got %0d bits, ones(0..4)=%0d ones(5..7)=%0d expected 0 and 3",
               obs_bits.size(), (obs_bits.size() >= 8) ? ones(0, 4) : -1,
               (obs_bits.size() >= 8) ? ones(5, 7) : -1);
    end
    checks++;
    if (accept_cyc != first_pop_cyc + 1) begin
      errors++;
      $display("FAIL handshake_accept_c: got cycle %0d expected %0d", accept_cyc, first_pop_cyc + 1);
    end
  endtask

  task automatic test_underrun_left();
    do_reset();
    channel = 1'b0; dec_num = 8'd4;
    repeat (40) half(5);
    checks++;
    if (urun_cnt != 4) begin
      errors++;
      $display("FAIL left_underrun: got %0d pulses expected 4", urun_cnt);
    end
    checks++;
    if (obs_bits.size() != 20) begin
      errors++;
      $display("FAIL left_bitcount: got %0d expected 20", obs_bits.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_bits[i] != bit'(i % 2)) begin
          errors++;
          $display("FAIL left_bit%0d: got %0d expected %0d", i, obs_bits[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    bit found;
    do_reset();
    channel = 1'b1; dec_num = 8'd3;
    stream_val = 0; stream_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      half(5);
      half(5);
      found = m_out && (q.size() == 2);
    end
    checks++;
    if (!found || data_out !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup: got data_out=%b expected 1 with 2 queued", data_out);
    end
    stream_en = 1'b0;
    src.delete();
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if (data_out !== 1'b0 || data_oe !== 1'b0 || pcm_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got out=%b oe=%b ready=%b expected 0 0 0",
               data_out, data_oe, pcm_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (pcm_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b expected 1", pcm_ready);
    end
    clear_obs();
    stream_val = 32767; stream_en = 1'b1;
    repeat (8) half(5);
    checks++;
    if (obs_bits.size() == 0 || obs_bits[0] != 1'b0) begin
      errors++;
      $display("FAIL midreset_first_bit: got %0d expected 0",
               (obs_bits.size() > 0) ? int'(obs_bits[0]) : -1);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      do_reset();
      channel     = 1'($urandom_range(1));
      dec_num     = 8'($urandom_range(6));
      stream_rand = 1'b1;
      stream_en   = 1'b1;
      valid_pct   = int'($urandom_range(100, 20));
      for (int h = 0; h < 60; h++) begin
        if ($urandom_range(9) == 0) dec_num = 8'($urandom_range(6));
        half(int'($urandom_range(9, 4)));
      end
    end
    stream_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mic_clk = 1'b0; channel = 1'b1; dec_num = 8'd3;
    pcm_valid = 1'b0; pcm_in = 16'sd0;
    m_acc = 0; m_cur = 0; m_cnt = 0; m_out = 0; m_oe = 0; m_urun = 0; pend = 0;
    first_pop_cyc = -1; accept_cyc = -1; urun_cnt = 0;
    test_reset();
    test_silence();
    test_full_scale();
    test_density();
    test_handshake();
    test_underrun_left();
    test_reset_mid_stream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
